// File: rtl/cache_sram_controller.sv
// Data-cache / SRAM controller: serves load hits from the cache, refills a 64-bit line
// from a 16-bit SRAM on a miss, and writes stores through to SRAM, invalidating the cached line.
module cache_sram_controller #(
    parameter int unsigned BASE_ADDR = 1024,
    parameter int unsigned SRAM_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [18:0] cache_address,
    output logic [63:0] cache_write_data,
    output logic        cache_read_en,
    output logic        cache_write_en,
    output logic        cache_invoke,
    input  logic [31:0] cache_read_data,
    input  logic        cache_hit,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    output logic        sram_we_n
);

    localparam int unsigned    CW       = (SRAM_WAIT > 0) ? $clog2(SRAM_WAIT + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(SRAM_WAIT);
    localparam logic [18:0]    BASE_LO  = 19'(BASE_ADDR);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        FILL,
        WR,
        DONE
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [18:0]    a_in;
    logic [18:0]    a_q;
    logic [31:0]    wdata_q;
    logic           is_write_q;
    logic [1:0]     beat;
    logic [CW-1:0]  cnt;
    logic [63:0]    line;
    logic           beat_end;
    logic           unused_addr_hi;

    // Only the low 19 offset bits are ever used, so the subtraction is done modulo 2^19.
    assign a_in           = address[18:0] - BASE_LO;
    assign unused_addr_hi = ^address[31:19];
    assign beat_end       = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_q        <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            beat       <= '0;
            cnt        <= '0;
            line       <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n != IDLE) begin
                a_q        <= a_in;
                wdata_q    <= wdata;
                is_write_q <= mem_w_en;
                beat       <= '0;
                cnt        <= '0;
            end else if (state == RD || state == WR) begin
                if (beat_end) begin
                    cnt  <= '0;
                    beat <= beat + 2'd1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
            if (state == RD && beat_end) begin
                line[{beat, 4'b0000} +: 16] <= sram_rdata;
            end
        end
    end

    always_comb begin
        state_n       = state;
        ready         = 1'b0;
        rdata         = '0;
        cache_read_en = 1'b0;
        cache_invoke  = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (!rst) begin
                    if (mem_w_en) begin
                        cache_invoke = 1'b1;
                        ready        = 1'b0;
                        state_n      = WR;
                    end else if (mem_r_en) begin
                        cache_read_en = 1'b1;
                        if (cache_hit) begin
                            rdata = cache_read_data;
                        end else begin
                            ready   = 1'b0;
                            state_n = RD;
                        end
                    end
                end
            end
            RD: begin
                if (beat_end && beat == 2'd3) state_n = FILL;
            end
            FILL: state_n = DONE;
            WR: begin
                if (beat_end && beat[0]) state_n = DONE;
            end
            DONE: begin
                ready   = 1'b1;
                state_n = IDLE;
                if (!is_write_q) rdata = a_q[2] ? line[63:32] : line[31:0];
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        cache_address    = (state == IDLE) ? a_in : a_q;
        cache_write_data = line;
        cache_write_en   = (state == FILL);
        sram_addr        = '0;
        sram_wdata       = '0;
        sram_we_n        = 1'b1;
        if (state == RD) begin
            sram_addr = {a_q[18:3], beat};
        end else if (state == WR) begin
            sram_addr  = {a_q[18:2], beat[0]};
            sram_wdata = beat[0] ? wdata_q[31:16] : wdata_q[15:0];
            sram_we_n  = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_sram_controller.sv
// Randomized bench for cache_sram_controller: a halfword SRAM model with a hold-time
// read window, plus a word-level reference memory that predicts every load result.
module tb_cache_sram_controller;

    localparam int unsigned BASE = 1024;
    localparam int unsigned SW   = 1;
    localparam int          W    = SW + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_r_en = 1'b0;
    logic        mem_w_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic [18:0] cache_address;
    logic [63:0] cache_write_data;
    logic        cache_read_en;
    logic        cache_write_en;
    logic        cache_invoke;
    logic [31:0] cache_read_data = '0;
    logic        cache_hit = 1'b0;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;
    logic        sram_we_n;

    int tests = 0;
    int fails = 0;

    cache_sram_controller #(
        .BASE_ADDR(BASE),
        .SRAM_WAIT(SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en),
        .address(address),
        .wdata(wdata),
        .rdata(rdata),
        .ready(ready),
        .cache_address(cache_address),
        .cache_write_data(cache_write_data),
        .cache_read_en(cache_read_en),
        .cache_write_en(cache_write_en),
        .cache_invoke(cache_invoke),
        .cache_read_data(cache_read_data),
        .cache_hit(cache_hit),
        .sram_addr(sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    // Power-on SRAM contents; halfwords 4..7 hold 0x1111..0x4444.
    function automatic logic [15:0] init_hw(input logic [8:0] i);
        if (i >= 9'd4 && i <= 9'd7) return 16'h1111 * 16'(i - 9'd3);
        return (16'(i) * 16'h0123) ^ 16'h5A5A;
    endfunction

    logic [15:0]  sram_mem [0:511];
    logic [511:0] sram_written = '0;
    logic [15:0]  ref_mem [0:511];
    logic [511:0] ref_written = '0;
    logic [17:0]  prev_addr = '1;
    int           run = 0;
    int           hold;

    function automatic logic [15:0] dev_rd(input logic [8:0] i);
        return sram_written[i] ? sram_mem[i] : init_hw(i);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [8:0] i);
        return ref_written[i] ? ref_mem[i] : init_hw(i);
    endfunction

    // Data is only valid once the address has been held for SRAM_WAIT+1 cycles.
    always_comb begin
        hold       = (sram_addr == prev_addr) ? run + 1 : 1;
        sram_rdata = (hold >= W) ? dev_rd(sram_addr[8:0]) : ~dev_rd(sram_addr[8:0]);
    end

    always @(posedge clk) begin
        if (!sram_we_n) begin
            sram_mem[sram_addr[8:0]]     <= sram_wdata;
            sram_written[sram_addr[8:0]] <= 1'b1;
        end
        if (sram_addr == prev_addr) run <= run + 1;
        else run <= 1;
        prev_addr <= sram_addr;
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if ({ready, sram_we_n, cache_read_en, cache_write_en, cache_invoke} !== 5'b11000) begin
            fails++;
            $display("FAIL reset_flags got=%b exp=11000",
                     {ready, sram_we_n, cache_read_en, cache_write_en, cache_invoke});
        end
        tests++;
        if ({rdata, sram_addr, sram_wdata, cache_write_data} !== '0) begin
            fails++;
            $display("FAIL reset_values got rdata=%h sram_addr=%h sram_wdata=%h line=%h exp=0",
                     rdata, sram_addr, sram_wdata, cache_write_data);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            tests++;
            if ({ready, sram_we_n, cache_read_en, cache_write_en, cache_invoke} !== 5'b11000) begin
                fails++;
                $display("FAIL idle_flags cyc=%0d got=%b exp=11000", i,
                         {ready, sram_we_n, cache_read_en, cache_write_en, cache_invoke});
            end
        end
    endtask

    task automatic test_read_hit(input logic [31:0] addr, input logic [31:0] d);
        logic [31:0] a;
        a = addr - BASE;
        @(negedge clk);
        mem_r_en = 1'b1; mem_w_en = 1'b0; address = addr; cache_hit = 1'b1; cache_read_data = d;
        #1;
        tests++;
        if (rdata !== d) begin
            fails++;
            $display("FAIL hit_rdata got=%h exp=%h", rdata, d);
        end
        tests++;
        if ({ready, cache_read_en, cache_invoke, cache_write_en, sram_we_n, sram_addr, cache_address}
            !== {5'b11001, 18'd0, a[18:0]}) begin
            fails++;
            $display("FAIL hit_flags got=%b/%h/%h exp=11001/0/%h",
                     {ready, cache_read_en, cache_invoke, cache_write_en, sram_we_n},
                     sram_addr, cache_address, a[18:0]);
        end
        @(negedge clk);
        mem_r_en = 1'b0; cache_hit = 1'b0;
        #1;
        tests++;
        if ({ready, cache_read_en, sram_we_n} !== 3'b101) begin
            fails++;
            $display("FAIL hit_after got=%b exp=101", {ready, cache_read_en, sram_we_n});
        end
    endtask

    task automatic test_read_miss(input logic [31:0] addr);
        logic [31:0] a;
        logic [63:0] exp_line;
        logic [31:0] exp_rd;
        logic [17:0] exp_sa;
        int          stall;
        bit          done;
        a = addr - BASE;
        for (int k = 0; k < 4; k++) exp_line[16*k +: 16] = ref_rd(9'(int'(a[18:3]) * 4 + k));
        exp_rd = a[2] ? exp_line[63:32] : exp_line[31:0];
        @(negedge clk);
        mem_r_en = 1'b1; mem_w_en = 1'b0; address = addr; cache_hit = 1'b0;
        cache_read_data = $urandom;
        #1;
        tests++;
        if ({ready, cache_read_en, cache_invoke, cache_write_en, sram_we_n, cache_address}
            !== {5'b01001, a[18:0]}) begin
            fails++;
            $display("FAIL miss_req got=%b/%h exp=01001/%h",
                     {ready, cache_read_en, cache_invoke, cache_write_en, sram_we_n},
                     cache_address, a[18:0]);
        end
        stall = 0;
        done  = 1'b0;
        for (int c = 0; c < 4 * W + 6 && !done; c++) begin
            @(negedge clk);
            mem_r_en = 1'b0; address = $urandom; cache_hit = 1'($urandom_range(0, 1));
            #1;
            tests++;
            if (c < 4 * W) begin
                exp_sa = {a[18:3], 2'(c / W)};
                if ({sram_addr, ready, sram_we_n, cache_write_en, cache_read_en, cache_invoke, cache_address}
                    !== {exp_sa, 5'b01000, a[18:0]}) begin
                    fails++;
                    $display("FAIL miss_beat c=%0d got=%h/%b/%h exp=%h/01000/%h", c, sram_addr,
                             {ready, sram_we_n, cache_write_en, cache_read_en, cache_invoke},
                             cache_address, exp_sa, a[18:0]);
                end
            end else if (c == 4 * W) begin
                if ({cache_write_en, ready, cache_read_en, cache_write_data, cache_address}
                    !== {3'b100, exp_line, a[18:0]}) begin
                    fails++;
                    $display("FAIL miss_fill got=%b/%h/%h exp=100/%h/%h",
                             {cache_write_en, ready, cache_read_en}, cache_write_data,
                             cache_address, exp_line, a[18:0]);
                end
            end else begin
                if ({ready, cache_write_en, cache_read_en, sram_we_n, rdata} !== {4'b1001, exp_rd}) begin
                    fails++;
                    $display("FAIL miss_done got=%b/%h exp=1001/%h",
                             {ready, cache_write_en, cache_read_en, sram_we_n}, rdata, exp_rd);
                end
            end
            if (ready) done = 1'b1;
            else stall++;
        end
        tests++;
        if (!done || stall != 4 * W + 1) begin
            fails++;
            $display("FAIL miss_latency got=%0d done=%0b exp=%0d", stall, done, 4 * W + 1);
        end
    endtask

    task automatic test_write(input logic [31:0] addr, input logic [31:0] d, input bit both);
        logic [31:0] a;
        logic [17:0] exp_sa;
        logic [15:0] exp_wd;
        int          stall;
        int          k;
        bit          done;
        a = addr - BASE;
        @(negedge clk);
        mem_w_en = 1'b1; mem_r_en = both; address = addr; wdata = d;
        cache_hit = 1'($urandom_range(0, 1));
        #1;
        tests++;
        if ({ready, cache_invoke, cache_read_en, cache_write_en, cache_address}
            !== {4'b0100, a[18:0]}) begin
            fails++;
            $display("FAIL wr_req both=%0b got=%b/%h exp=0100/%h", both,
                     {ready, cache_invoke, cache_read_en, cache_write_en}, cache_address, a[18:0]);
        end
        stall = 0;
        done  = 1'b0;
        for (int c = 0; c < 2 * W + 6 && !done; c++) begin
            @(negedge clk);
            mem_w_en = 1'b0; mem_r_en = 1'b0; address = $urandom; wdata = $urandom;
            #1;
            tests++;
            if (c < 2 * W) begin
                k      = c / W;
                exp_sa = {a[18:2], 1'(k)};
                exp_wd = (k != 0) ? d[31:16] : d[15:0];
                if ({sram_addr, sram_wdata, sram_we_n, ready, cache_invoke, cache_read_en, cache_write_en}
                    !== {exp_sa, exp_wd, 5'b00000}) begin
                    fails++;
                    $display("FAIL wr_beat c=%0d got=%h/%h/%b exp=%h/%h/00000", c, sram_addr, sram_wdata,
                             {sram_we_n, ready, cache_invoke, cache_read_en, cache_write_en}, exp_sa, exp_wd);
                end
            end else begin
                if ({ready, sram_we_n, cache_invoke, cache_read_en, cache_write_en} !== 5'b11000) begin
                    fails++;
                    $display("FAIL wr_done got=%b exp=11000",
                             {ready, sram_we_n, cache_invoke, cache_read_en, cache_write_en});
                end
            end
            if (ready) done = 1'b1;
            else stall++;
        end
        tests++;
        if (!done || stall != 2 * W) begin
            fails++;
            $display("FAIL wr_latency got=%0d done=%0b exp=%0d", stall, done, 2 * W);
        end
        ref_mem[9'(int'(a[18:2]) * 2)]         = d[15:0];
        ref_written[9'(int'(a[18:2]) * 2)]     = 1'b1;
        ref_mem[9'(int'(a[18:2]) * 2 + 1)]     = d[31:16];
        ref_written[9'(int'(a[18:2]) * 2 + 1)] = 1'b1;
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] a;
        int          fills;
        a = 32'(BASE) + 32'd32 - BASE;
        @(negedge clk);
        mem_r_en = 1'b1; mem_w_en = 1'b0; address = 32'(BASE) + 32'd32; cache_hit = 1'b0;
        repeat (2 * W + 1) begin
            @(negedge clk);
            mem_r_en = 1'b0;
        end
        rst = 1'b1;
        #1;
        tests++;
        if (sram_addr !== {a[18:3], 2'd2}) begin
            fails++;
            $display("FAIL rstmid_beat2 got=%h exp=%h", sram_addr, {a[18:3], 2'd2});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if ({ready, cache_write_en, sram_we_n, cache_read_en, sram_addr} !== {4'b1010, 18'd0}) begin
            fails++;
            $display("FAIL rstmid_idle got=%b/%h exp=1010/0",
                     {ready, cache_write_en, sram_we_n, cache_read_en}, sram_addr);
        end
        fills = 0;
        for (int i = 0; i < 4 * W + 2; i++) begin
            @(negedge clk);
            #1;
            if (cache_write_en) fills++;
        end
        tests++;
        if (fills != 0) begin
            fails++;
            $display("FAIL rstmid_nofill got=%0d exp=0", fills);
        end
        test_read_miss(32'(BASE) + 32'd32);
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        mem_w_en = 1'b1; mem_r_en = 1'b0; address = 32'(BASE) + 32'h300; wdata = 32'h12345678;
        repeat (W + 1) begin
            @(negedge clk);
            mem_w_en = 1'b0;
        end
        rst = 1'b1;
        #1;
        tests++;
        if (sram_we_n !== 1'b0) begin
            fails++;
            $display("FAIL rstwr_active got=%b exp=0", sram_we_n);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if ({sram_we_n, ready, sram_addr, sram_wdata} !== {2'b11, 34'd0}) begin
            fails++;
            $display("FAIL rstwr_abort got=%b/%h/%h exp=11/0/0", {sram_we_n, ready}, sram_addr, sram_wdata);
        end
    endtask

    task automatic test_random(input int n);
        logic [31:0] addr;
        int          op;
        for (int i = 0; i < n; i++) begin
            addr = 32'(BASE) + 32'($urandom_range(0, 63)) * 32'd4;
            op   = $urandom_range(0, 3);
            case (op)
                0:       test_read_hit(addr, $urandom);
                1:       test_read_miss(addr);
                2:       test_write(addr, $urandom, 1'b0);
                default: test_write(addr, $urandom, 1'b1);
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_read_miss(32'd1032);
        test_read_hit(32'd1036, 32'hDEADBEEF);
        test_write(32'd1040, 32'hCAFEF00D, 1'b0);
        test_read_miss(32'd1040);
        test_write(32'd1044, 32'h0BADC0DE, 1'b1);
        test_read_miss(32'd1044);
        test_reset_mid_read();
        test_reset_mid_write();
        test_read_miss(32'(BASE) - 32'd8);
        test_read_miss(32'(BASE) - 32'd4);
        test_random(60);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1);
    end

endmodule
